// File: rtl/oam_pkg.sv
// Shared definitions for the OAM DMA block: entry geometry, field
// offsets inside a 32-bit sprite entry, and the transfer FSM states.
package oam_pkg;

    localparam int OAM_ENTRIES = 64;
    localparam int ENTRY_W     = 32;
    localparam int ADDR_W      = 6;
    localparam int FIELD_W     = 8;

    // Entry layout: {pal, tile, y, x}
    localparam int X_LSB    = 0;
    localparam int Y_LSB    = 8;
    localparam int TILE_LSB = 16;
    localparam int PAL_LSB  = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRIVE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/shadow_oam_ram.sv
// Shadow OAM: 64 x 32 storage, one write port and one synchronous
// read-first read port. The read register only updates on i_re so the
// fetched entry stays stable while it is being driven to the PPU.
module shadow_oam_ram
    import oam_pkg::*;
(
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic                i_we,
    input  logic [ADDR_W-1:0]   i_waddr,
    input  logic [ENTRY_W-1:0]  i_wdata,
    input  logic                i_re,
    input  logic [ADDR_W-1:0]   i_raddr,
    output logic [ENTRY_W-1:0]  o_rdata
);

    logic [ENTRY_W-1:0] r_mem [OAM_ENTRIES];
    logic [ENTRY_W-1:0] r_rdata;

    // Storage array: contents survive reset.
    always_ff @(posedge CLOCK_50) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read; same-cycle write to the same entry returns old data.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/oam_dma.sv
// OAM DMA: copies NUM_SPRITES shadow entries to the PPU OAM, holding each
// write for HOLD_CYCLES clocks. Triggered by dma_start and, when the macro
// OAM_DMA_VSYNC_TRIG_EN is defined, by a synchronized vsync falling edge.
module oam_dma
    import oam_pkg::*;
#(
    parameter int NUM_SPRITES = 64,
    parameter int HOLD_CYCLES = 4
)(
    input  logic         CLOCK_50,
    input  logic         reset_n,
    input  logic         vsync,
    input  logic         dma_start,
    input  logic         sh_we,
    input  logic [5:0]   sh_addr,
    input  logic [31:0]  sh_data,
    output logic [31:0]  cpu_oam_data,
    output logic [5:0]   cpu_oam_addr,
    output logic         cpu_write,
    output logic         busy,
    output logic         frame_done,
    output logic         overrun
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_SPRITES - 1);
    localparam logic [3:0]        LAST_HOLD = 4'(HOLD_CYCLES - 1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_index;
    logic [3:0]          r_hold;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_overrun;
    logic                w_vs_fall;
    logic                w_trigger;
    logic                w_rd_en;
    logic [ENTRY_W-1:0]  w_rd_data;

`ifdef OAM_DMA_VSYNC_TRIG_EN
    logic r_vs_s1;
    logic r_vs_s2;
    logic r_vs_prev;

    // Two-flop synchronizer plus one delay stage for falling-edge detect.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_s1   <= 1'b1;
            r_vs_s2   <= 1'b1;
            r_vs_prev <= 1'b1;
        end else begin
            r_vs_s1   <= vsync;
            r_vs_s2   <= r_vs_s1;
            r_vs_prev <= r_vs_s2;
        end
    end

    assign w_vs_fall = r_vs_prev & ~r_vs_s2;
`else
    logic w_unused_vsync;
    assign w_unused_vsync = vsync;
    assign w_vs_fall      = 1'b0;
`endif

    // Both sources OR together so a coincident edge and request start one transfer.
    assign w_trigger = dma_start | w_vs_fall;
    assign w_rd_en   = (r_state == FETCH);

    shadow_oam_ram u_shadow (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .i_we     (sh_we),
        .i_waddr  (sh_addr),
        .i_wdata  (sh_data),
        .i_re     (w_rd_en),
        .i_raddr  (r_index),
        .o_rdata  (w_rd_data)
    );

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        w_next     = r_state;
        cpu_write  = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_trigger) begin
                    w_next = FETCH;
                end
            end
            FETCH: begin
                w_next = DRIVE;
            end
            DRIVE: begin
                cpu_write = 1'b1;
                if (r_hold == LAST_HOLD) begin
                    w_next = (r_index == LAST_IDX) ? DONE : FETCH;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                w_next     = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Entry index, hold counter and latched PPU address.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_index <= '0;
            r_hold  <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_index <= '0;
                    end
                end
                FETCH: begin
                    r_hold <= '0;
                    r_addr <= r_index;
                end
                DRIVE: begin
                    if (r_hold == LAST_HOLD) begin
                        if (r_index != LAST_IDX) begin
                            r_index <= r_index + 6'd1;
                        end
                    end else begin
                        r_hold <= r_hold + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sticky flag: a trigger arrived while a transfer was already running.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (w_trigger && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

    assign cpu_oam_data = w_rd_data;
    assign cpu_oam_addr = r_addr;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_oam_dma.sv
// Testbench for oam_dma: scoreboard of expected PPU writes pushed at trigger
// time and popped as each cpu_write window starts.
module tb_oam_dma;

    localparam int N = 64;
    localparam int H = 4;
    localparam int BOUND = 2000;

    logic        CLOCK_50;
    logic        reset_n;
    logic        vsync;
    logic        dma_start;
    logic        sh_we;
    logic [5:0]  sh_addr;
    logic [31:0] sh_data;
    logic [31:0] cpu_oam_data;
    logic [5:0]  cpu_oam_addr;
    logic        cpu_write;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    oam_dma #(.NUM_SPRITES(N), .HOLD_CYCLES(H)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset_n      (reset_n),
        .vsync        (vsync),
        .dma_start    (dma_start),
        .sh_we        (sh_we),
        .sh_addr      (sh_addr),
        .sh_data      (sh_data),
        .cpu_oam_data (cpu_oam_data),
        .cpu_oam_addr (cpu_oam_addr),
        .cpu_write    (cpu_write),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pc       = 0;
    int          fd_cnt   = 0;
    int          fd_pc    = 0;
    int          start_pc = 0;
    int          hold_cnt = 0;
    int          fd_base  = 0;
    logic        prev_w   = 1'b0;
    logic        unstable = 1'b0;
    logic        wr_seen  = 1'b0;
    logic [5:0]  cur_a    = '0;
    logic [31:0] cur_d    = '0;
    logic [37:0] sb [$];
    logic [31:0] sh_model [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    initial begin
        forever begin
            @(posedge CLOCK_50);
            pc++;
        end
    end

    // Monitor: pops the scoreboard on each write window and checks its length.
    initial begin
        logic [37:0] e;
        forever begin
            @(negedge CLOCK_50);
            if (!reset_n) begin
                prev_w   = 1'b0;
                hold_cnt = 0;
            end else begin
                if (cpu_write) wr_seen = 1'b1;
                if (frame_done) begin
                    fd_cnt++;
                    fd_pc = pc;
                end
                if (cpu_write && !prev_w) begin
                    hold_cnt = 1;
                    unstable = 1'b0;
                    cur_a    = cpu_oam_addr;
                    cur_d    = cpu_oam_data;
                    chk("sb_avail", 64'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("wr_addr", 64'(cpu_oam_addr), 64'(e[37:32]));
                        chk("wr_data", 64'(cpu_oam_data), 64'(e[31:0]));
                    end
                end else if (cpu_write) begin
                    hold_cnt++;
                    if (cpu_oam_addr != cur_a || cpu_oam_data != cur_d) unstable = 1'b1;
                end else if (prev_w) begin
                    chk("hold_len", 64'(hold_cnt), 64'(H));
                    chk("hold_stable", 64'(unstable), 0);
                end
                prev_w = cpu_write;
            end
        end
    end

    task automatic push_transfer();
        for (int i = 0; i < N; i++) sb.push_back({6'(i), sh_model[i]});
    endtask

    task automatic sh_write(input int a, input logic [31:0] d);
        @(negedge CLOCK_50);
        sh_we   = 1'b1;
        sh_addr = 6'(a);
        sh_data = d;
        sh_model[a] = d;
        @(negedge CLOCK_50);
        sh_we = 1'b0;
    endtask

    task automatic start_dma();
        @(negedge CLOCK_50);
        push_transfer();
        start_pc  = pc;
        dma_start = 1'b1;
        @(negedge CLOCK_50);
        dma_start = 1'b0;
    endtask

    task automatic wait_fd(input int target, input string tag);
        int i;
        for (i = 0; i < BOUND; i++) begin
            if (fd_cnt >= target) break;
            @(negedge CLOCK_50);
        end
        chk(tag, 64'(fd_cnt >= target), 1);
    endtask

    task automatic wait_write_at(input int a, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge CLOCK_50);
            if (cpu_write && cpu_oam_addr == 6'(a)) begin
                found = 1'b1;
                break;
            end
        end
        chk(tag, 64'(found), 1);
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge CLOCK_50);
        reset_n = 1'b1;
    endtask

    initial begin
        logic busy_seen;
        reset_n   = 1'b0;
        vsync     = 1'b1;
        dma_start = 1'b0;
        sh_we     = 1'b0;
        sh_addr   = '0;
        sh_data   = '0;
        #1;
        chk("rst_write", 64'(cpu_write), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_fd", 64'(frame_done), 0);
        chk("rst_overrun", 64'(overrun), 0);
        chk("rst_addr", 64'(cpu_oam_addr), 0);
        chk("rst_data", 64'(cpu_oam_data), 0);
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;

        // Fill the shadow, one entry per cycle.
        @(negedge CLOCK_50);
        for (int i = 0; i < N; i++) begin
            sh_we   = 1'b1;
            sh_addr = 6'(i);
            sh_data = (i == 0) ? 32'h0105_6400 : $urandom;
            sh_model[i] = sh_data;
            @(negedge CLOCK_50);
        end
        sh_we = 1'b0;

        // Basic transfer and latency.
        fd_base = fd_cnt;
        start_dma();
        chk("busy_run", 64'(busy), 1);
        wait_fd(fd_base + 1, "fd_basic");
        chk("latency", 64'(fd_pc - start_pc), 64'(N * (1 + H) + 1));
        @(negedge CLOCK_50);
        chk("busy_idle", 64'(busy), 0);
        chk("sb_empty_a", 64'(sb.size()), 0);
        chk("no_overrun_a", 64'(overrun), 0);

        // Request while busy: ignored, sets overrun.
        fd_base = fd_cnt;
        start_dma();
        wait_write_at(10, "reach_10");
        dma_start = 1'b1;
        @(negedge CLOCK_50);
        dma_start = 1'b0;
        wait_fd(fd_base + 1, "fd_overrun");
        repeat (N * (1 + H) + 20) @(negedge CLOCK_50);
        chk("fd_once", 64'(fd_cnt - fd_base), 1);
        chk("overrun_set", 64'(overrun), 1);
        chk("sb_empty_b", 64'(sb.size()), 0);
        chk("busy_idle_b", 64'(busy), 0);

        // Shadow writes during a transfer.
        do_reset();
        chk("overrun_clr", 64'(overrun), 0);
        fd_base = fd_cnt;
        start_dma();
        wait_write_at(20, "reach_20");
        sh_write(40, 32'hAABB_CCDD);
        foreach (sb[i]) if (sb[i][37:32] == 6'd40) sb[i][31:0] = 32'hAABB_CCDD;
        sh_write(5, 32'h1122_3344);
        wait_fd(fd_base + 1, "fd_midwrite");
        chk("sb_empty_c", 64'(sb.size()), 0);

        // Reset in the middle of a DRIVE window, then restart.
        fd_base = fd_cnt;
        start_dma();
        wait_write_at(30, "reach_30");
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_write", 64'(cpu_write), 0);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_addr", 64'(cpu_oam_addr), 0);
        chk("abort_data", 64'(cpu_oam_data), 0);
        sb.delete();
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        chk("abort_no_fd", 64'(fd_cnt - fd_base), 0);
        fd_base = fd_cnt;
        start_dma();
        wait_fd(fd_base + 1, "fd_restart");
        chk("sb_empty_d", 64'(sb.size()), 0);
        repeat (5) @(negedge CLOCK_50);

`ifdef OAM_DMA_VSYNC_TRIG_EN
        // Vsync falling edge starts exactly one transfer, three cycles later.
        fd_base = fd_cnt;
        @(negedge CLOCK_50);
        push_transfer();
        vsync = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        chk("vs_busy_pre", 64'(busy), 0);
        @(negedge CLOCK_50);
        chk("vs_busy_start", 64'(busy), 1);
        repeat (93) @(negedge CLOCK_50);
        vsync = 1'b1;
        wait_fd(fd_base + 1, "fd_vsync");
        repeat (50) @(negedge CLOCK_50);
        chk("vs_fd_once", 64'(fd_cnt - fd_base), 1);
        chk("vs_overrun", 64'(overrun), 0);
        chk("sb_empty_e", 64'(sb.size()), 0);
`else
        // Vsync has no effect in this build.
        wr_seen   = 1'b0;
        busy_seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            vsync = 1'b0;
            repeat (8) begin
                @(negedge CLOCK_50);
                busy_seen = busy_seen | busy;
            end
            vsync = 1'b1;
            repeat (8) begin
                @(negedge CLOCK_50);
                busy_seen = busy_seen | busy;
            end
        end
        chk("vs_ign_busy", 64'(busy_seen), 0);
        chk("vs_ign_write", 64'(wr_seen), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 64, meaning entries per transfer (1..64).
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, meaning CLOCK_50 cycles each entry is held with cpu_write high (2..15).
REQ-003 SHALL have port CLOCK_50  input  1  system clock, 50 MHz.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port vsync  input  1  VGA vsync from the 25 MHz domain, active-low pulse.
REQ-006 SHALL have port dma_start  input  1  one-cycle manual transfer request.
REQ-007 SHALL have port sh_we  input  1  shadow OAM write enable.
REQ-008 SHALL have port sh_addr  input  6  shadow OAM entry index.
REQ-009 SHALL have port sh_data  input  32  shadow entry {pal[31:24], tile[23:16], y[15:8], x[7:0]}.
REQ-010 SHALL have port cpu_oam_data  output  32  entry driven to PPU OAM.
REQ-011 SHALL have port cpu_oam_addr  output  6  PPU OAM index.
REQ-012 SHALL have port cpu_write  output  1  PPU OAM write strobe.
REQ-013 SHALL have port busy  output  1  transfer in progress.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after the last entry is written.
REQ-015 SHALL have port overrun  output  1  sticky: trigger arrived while busy.

Function
REQ-016 SHALL store sh_data into shadow entry sh_addr on every cycle with sh_we=1, including while busy.
REQ-017 SHALL synchronize vsync through two flops; trigger = synchronized falling edge.
REQ-018 SHALL use FSM states IDLE, FETCH, DRIVE, DONE.
REQ-019 IDLE -> FETCH on trigger (vsync edge or dma_start); index cleared to 0.
REQ-020 FETCH: issue shadow read at index, data valid next cycle (1-cycle latency), -> DRIVE.
REQ-021 DRIVE: cpu_oam_addr=index, cpu_oam_data=read data, cpu_write=1, all stable for exactly HOLD_CYCLES cycles.
REQ-022 Leaving DRIVE: index==NUM_SPRITES-1 -> DONE, else index+1 -> FETCH.
REQ-023 DONE: frame_done=1 one cycle, -> IDLE.
REQ-024 busy=1 in FETCH, DRIVE, DONE; 0 in IDLE.
REQ-025 cpu_write SHALL be 0 in every state except DRIVE; cpu_oam_data/addr hold last values outside DRIVE.
REQ-026 Transfer latency, trigger to frame_done: NUM_SPRITES*(1+HOLD_CYCLES)+1 cycles.
REQ-027 Trigger while busy SHALL be ignored and set overrun; simultaneous vsync edge and dma_start in IDLE SHALL start one transfer only.
REQ-028 Shadow write to the entry read in the same cycle: read returns old data (read-first).
REQ-029 Shadow write to an entry not yet fetched SHALL appear in the current transfer; to an entry already fetched, next transfer.
REQ-030 Index arithmetic 6-bit; no wrap beyond NUM_SPRITES-1.

Reset
REQ-031 reset_n low SHALL immediately force IDLE, index=0, cpu_write=0, cpu_oam_data=0, cpu_oam_addr=0, busy=0, frame_done=0, overrun=0, sync flops=1.
REQ-032 Reset mid-transfer SHALL abort without completing the current entry; shadow contents are not cleared.

Configuration
REQ-033 Macro OAM_DMA_VSYNC_TRIG_EN defined: vsync falling edge and dma_start both trigger.
REQ-034 Macro OAM_DMA_VSYNC_TRIG_EN undefined: vsync ignored (synchronizer removed), only dma_start triggers.

Structure
REQ-035 Package oam_pkg SHALL hold entry field offsets, OAM_ENTRIES=64, entry width 32, and the FSM state enum.
REQ-036 Sub-module shadow_oam_ram: 64x32, one write port, one synchronous read-first read port.

Verification
REQ-037 Reset, write entry 0 = 0x01056400, dma_start -> cpu_write high 4 cycles with addr 0, data 0x01056400; frame_done at cycle 64*5+1=321.
REQ-038 With macro defined, vsync high->low (held low 96 clocks) -> exactly one transfer starts 3 cycles after the edge.
REQ-039 dma_start during busy at entry 10 -> overrun=1, no second transfer, frame_done pulses once.
REQ-040 During transfer at index 20, write entry 40=0xAABBCCDD and entry 5=0x11223344 -> PPU sees entry 40 new, entry 5 old.
REQ-041 Assert reset_n low at index 30 during DRIVE -> cpu_write=0 and busy=0 same cycle; next dma_start restarts at addr 0.
REQ-042 Macro undefined, toggle vsync 10 times -> busy stays 0, cpu_write never asserted.
